// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain controller.
// State encoding is fixed at 2 bits; the idle timer width is shared with the timer sub-block.
package fifo_drain_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  // Only the burst-moving states count as busy.
  function automatic logic is_busy(input state_e st);
    is_busy = (st == ST_LOAD) || (st == ST_SEND);
  endfunction

endpackage

// File: rtl/fifo_drain_timer.sv
// Idle-cycle counter for the drain controller: counts while enabled, clears on request,
// and flags when the count reaches limit-1 (limit of zero disables the flag).
module fifo_drain_timer
  import fifo_drain_pkg::*;
(
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [TIMER_W-1:0] limit,
  output logic               match
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear has priority, the counter wraps naturally at full scale.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {TIMER_W{1'b0}};
    end else if (inc) begin
      count_d = count_q + TIMER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign match = (limit != {TIMER_W{1'b0}}) && (count_q == (limit - TIMER_W'(1)));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an external first-word-fall-through FIFO in bursts onto a valid/ready stream,
// triggered by an occupancy threshold or by an idle timeout.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               enable,
  input  logic [AW:0]        threshold,
  input  logic [TIMER_W-1:0] timeout,
  input  logic [DW-1:0]      fifo_data_out,
  input  logic               fifo_empty,
  input  logic [AW:0]        fifo_number_samples,
  output logic               fifo_pop,
  output logic [DW-1:0]      m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic [15:0]        burst_count,
  output logic               err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e       state_q, state_d;
  logic [AW:0]  remaining_q, remaining_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic         m_valid_q, m_valid_d;
  logic         m_last_q, m_last_d;
  logic         busy_q, busy_d;
  logic [15:0]  burst_count_q, burst_count_d;
  logic         err_q, err_d;

  logic [AW:0]  eff_thr_s;
  logic         thr_hit_s;
  logic         tmo_hit_s;
  logic         timer_clr_s;
  logic         timer_inc_s;
  logic         timer_match_s;

  // Thresholds above the FIFO depth could never be reached, so clamp them.
  assign eff_thr_s   = (threshold > DEPTH_L) ? DEPTH_L : threshold;
  assign thr_hit_s   = (eff_thr_s != {(AW+1){1'b0}}) && (fifo_number_samples >= eff_thr_s);
  assign tmo_hit_s   = timer_match_s && !fifo_empty;
  assign timer_clr_s = (state_q != ST_WAIT) || fifo_empty;
  assign timer_inc_s = (state_q == ST_WAIT) && !fifo_empty;

  fifo_drain_timer u_timer (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .clr    (timer_clr_s),
    .inc    (timer_inc_s),
    .limit  (timeout),
    .match  (timer_match_s)
  );

  // Next-state and next-output logic for the drain FSM.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    burst_count_d = burst_count_q;
    err_d         = err_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (thr_hit_s) begin
          state_d     = ST_LOAD;
          remaining_d = eff_thr_s;
        end else if (tmo_hit_s) begin
          state_d     = ST_LOAD;
          remaining_d = fifo_number_samples;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_LOAD: begin
        if (fifo_empty) begin
          // Someone else drained the FIFO under us: abandon the burst.
          err_d   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          m_data_d    = fifo_data_out;
          m_last_d    = (remaining_q == (AW+1)'(1));
          remaining_d = remaining_q - (AW+1)'(1);
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          if (m_last_q) begin
            burst_count_d = burst_count_q + 16'd1;
            m_last_d      = 1'b0;
            state_d       = enable ? ST_WAIT : ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    m_valid_d = (state_d == ST_SEND);
    busy_d    = is_busy(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= {(AW+1){1'b0}};
      m_data_q      <= {DW{1'b0}};
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      burst_count_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      burst_count_q <= burst_count_d;
      err_q         <= err_d;
    end
  end

  assign fifo_pop    = (state_q == ST_LOAD) && !fifo_empty;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign burst_count = burst_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a queue-based FWFT FIFO and a burst-level
// reference model (expected words, expected m_last pattern, expected burst count and first-beat time).
module tb_fifo_drain_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          wb_clk;
  logic          wb_rst;
  logic          enable;
  logic [AW:0]   threshold;
  logic [15:0]   timeout;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic [AW:0]   fifo_number_samples;
  logic          fifo_pop;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_count;
  logic          err;

  fifo_drain_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .wb_clk              (wb_clk),
    .wb_rst              (wb_rst),
    .enable              (enable),
    .threshold           (threshold),
    .timeout             (timeout),
    .fifo_data_out       (fifo_data_out),
    .fifo_empty          (fifo_empty),
    .fifo_number_samples (fifo_number_samples),
    .fifo_pop            (fifo_pop),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_last              (m_last),
    .busy                (busy),
    .burst_count         (burst_count),
    .err                 (err)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data_q[$];
  bit            exp_last_q[$];

  int checks = 0;
  int failures = 0;
  int step_idx, push_left, push_idx, pat_mode, ready_mode, hs_cnt, first_valid_step, clear_at;
  int exp_burst_total = 0;
  bit prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic s_pop, s_valid, s_last, s_busy;
  logic [DW-1:0] s_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: present FIFO state, sample and check DUT, then apply FIFO updates.
  task automatic step();
    logic [DW-1:0] w;
    logic [7:0] b;
    @(negedge wb_clk);
    fifo_empty          = (fifo_q.size() == 0);
    fifo_number_samples = (AW+1)'(fifo_q.size());
    fifo_data_out       = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = (step_idx % 3 == 0);
      2: m_ready = 1'($urandom_range(0, 1));
      3: m_ready = (hs_cnt == 0);
      default: m_ready = 1'b1;
    endcase
    #1;
    s_pop = fifo_pop; s_valid = m_valid; s_last = m_last; s_data = m_data; s_busy = busy;
    if (s_pop) check_val("pop_while_empty", fifo_empty, 32'd0);
    if (s_valid) check_val("busy_in_send", s_busy, 32'd1);
    if (prev_stall) begin
      check_val("hold_valid", s_valid, 32'd1);
      check_val("hold_data", s_data, prev_data);
      check_val("hold_last", s_last, prev_last);
    end
    if (s_valid && first_valid_step < 0) first_valid_step = step_idx;
    if (s_valid && m_ready) begin
      check_val("beat_expected", (exp_data_q.size() > 0), 32'd1);
      if (exp_data_q.size() > 0) begin
        check_val("beat_data", s_data, exp_data_q.pop_front());
        check_val("beat_last", s_last, exp_last_q.pop_front());
      end
      hs_cnt++;
    end
    prev_stall = s_valid && !m_ready;
    prev_data  = s_data;
    prev_last  = s_last;
    @(posedge wb_clk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (step_idx == clear_at) begin
      fifo_q.delete();
      exp_data_q.delete();
      exp_last_q.delete();
    end
    if (push_left > 0) begin
      b = push_idx[7:0];
      w = (pat_mode == 0) ? {4{b}} : $urandom;
      fifo_q.push_back(w);
      exp_data_q.push_back(w);
      push_left--;
      push_idx++;
    end
    step_idx++;
  endtask

  // Burst-level model: full threshold bursts, then one timeout burst or single-word drain.
  task automatic run_scenario(input int thr, input int to, input int n, input int rmode, input int pmode);
    int eff, full, left, exp_first;
    bit timing_known;
    threshold = thr[AW:0];
    timeout   = to[15:0];
    eff  = (thr > DEPTH) ? DEPTH : thr;
    full = (eff > 0) ? n / eff : 0;
    left = (eff > 0) ? n % eff : n;
    for (int k = 0; k < full; k++)
      for (int i = 0; i < eff; i++) exp_last_q.push_back(i == eff - 1);
    if (left > 0 && to != 0) begin
      for (int i = 0; i < left; i++) exp_last_q.push_back(i == left - 1);
      exp_burst_total += full + 1;
    end else begin
      for (int i = 0; i < left; i++) exp_last_q.push_back(1'b1);
      exp_burst_total += full + left;
    end
    timing_known = (eff > 0 && n >= eff) || (to != 0);
    exp_first    = (eff > 0 && n >= eff) ? eff + 2 : to + 2;
    first_valid_step = -1; step_idx = 0; push_left = n; push_idx = 0;
    ready_mode = rmode; pat_mode = pmode; hs_cnt = 0; clear_at = -1;
    for (int c = 0; c < 800 && !(push_left == 0 && exp_data_q.size() == 0); c++) begin
      if (to == 0 && left > 0 && push_left == 0 && exp_data_q.size() == left) threshold = 5'd1;
      step();
    end
    check_val("drain_complete", exp_data_q.size(), 32'd0);
    check_val("last_pattern_used", exp_last_q.size(), 32'd0);
    if (timing_known) check_val("first_valid_cycle", first_valid_step, exp_first);
    ready_mode = 0;
    repeat (4) step();
    check_val("burst_count", burst_count, exp_burst_total[15:0]);
    check_val("fifo_drained", fifo_q.size(), 32'd0);
    check_val("err_clean", err, 32'd0);
    check_val("busy_after", busy, 32'd0);
    check_val("valid_after", m_valid, 32'd0);
  endtask

  initial begin
    wb_rst = 1'b0; enable = 1'b0; threshold = '0; timeout = '0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_number_samples = '0; fifo_data_out = '0;
    step_idx = 0; push_left = 0; push_idx = 0; pat_mode = 0; ready_mode = 0;
    hs_cnt = 0; first_valid_step = -1; clear_at = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    #3;
    check_val("rst_pop", fifo_pop, 32'd0);
    check_val("rst_valid", m_valid, 32'd0);
    check_val("rst_last", m_last, 32'd0);
    check_val("rst_data", m_data, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_bursts", burst_count, 32'd0);
    check_val("rst_err", err, 32'd0);
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    enable = 1'b1;

    // Armed but nothing to drain.
    for (int i = 0; i < 100; i++) begin
      step();
      check_val("idle_no_pop", s_pop, 32'd0);
      check_val("idle_no_valid", s_valid, 32'd0);
    end

    run_scenario(4, 0, 4, 0, 0);
    run_scenario(0, 10, 3, 0, 0);
    run_scenario(20, 0, 16, 1, 0);
    for (int r = 0; r < 8; r++) begin
      int n, thr, eff, to;
      n   = $urandom_range(1, 16);
      thr = $urandom_range(0, 24);
      eff = (thr > DEPTH) ? DEPTH : thr;
      to  = (eff == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(n + 2, 40) : 0;
      run_scenario(thr, to, n, 2, 1);
    end

    // FIFO emptied behind the controller's back as it enters LOAD.
    threshold = 5'd4; timeout = 16'd0;
    step_idx = 0; push_left = 4; push_idx = 0; pat_mode = 0; ready_mode = 0; clear_at = 4;
    first_valid_step = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (step_idx == 6) check_val("abort_no_pop", s_pop, 32'd0);
    end
    clear_at = -1;
    check_val("abort_err", err, 32'd1);
    check_val("abort_no_beat", (first_valid_step < 0), 32'd1);
    check_val("abort_bursts", burst_count, exp_burst_total[15:0]);
    repeat (5) step();
    check_val("err_sticky", err, 32'd1);
    enable = 1'b0;
    repeat (3) step();
    check_val("err_cleared_idle", err, 32'd0);
    enable = 1'b1;
    repeat (3) step();

    // Reset arriving while beat 2 of 4 is on the bus.
    threshold = 5'd4; timeout = 16'd0;
    step_idx = 0; push_left = 4; push_idx = 0; pat_mode = 0; ready_mode = 3; hs_cnt = 0;
    exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0);
    exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b1);
    for (int c = 0; c < 60 && !(s_valid && hs_cnt == 1); c++) step();
    check_val("beat2_reached", (s_valid && hs_cnt == 1), 32'd1);
    check_val("bursts_before_rst", (burst_count != 16'd0), 32'd1);
    wb_rst = 1'b0;
    #1;
    check_val("midrst_valid", m_valid, 32'd0);
    check_val("midrst_pop", fifo_pop, 32'd0);
    check_val("midrst_bursts", burst_count, 32'd0);
    check_val("midrst_busy", busy, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge wb_clk); #1;
      check_val("inrst_pop", fifo_pop, 32'd0);
      check_val("inrst_valid", m_valid, 32'd0);
    end
    @(negedge wb_clk);
    wb_rst = 1'b1;
    fifo_q.delete(); exp_data_q.delete(); exp_last_q.delete();
    exp_burst_total = 0; prev_stall = 1'b0; ready_mode = 0; push_left = 0;
    repeat (3) step();
    run_scenario(2, 0, 4, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
